adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_pkg.sv | 18 +
 rtl/adder.sv | 22 ++
 rtl/adder_arbiter.sv | 118 +++++++++++
 tb/tb_adder_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder arbiter: datapath width, FSM encoding and
// the debug view of the controller.
package adder_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    state_t state;
    logic   rr_ptr;
  } dbg_t;

endpackage

// File: rtl/adder.sv
// Shared 16-bit combinational ripple-carry adder, no carry-in.
module adder
  import adder_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry
);

  logic [DATA_W:0] w_c;

  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_carry = w_c[DATA_W];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter time-sharing one adder between two requesters,
// one operation in flight: IDLE (grant) -> EXEC (add) -> RESP (hold result).
module adder_arbiter
  import adder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_sum,
  output logic              resp_carry,
  output dbg_t              o_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a requester holds valid and operands until it sees ready.
  state_t            r_state;
  state_t            w_next;
  logic              r_rr_ptr;
  logic              r_id;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_sum;
  logic              r_carry;
  logic              r_resp_valid;

  logic              w_grant_id;
  logic [1:0]        w_req_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_sum;
  logic              w_carry;

  always_comb begin
    w_grant_id  = 1'b0;
    w_req_ready = 2'b00;
    if (req_valid == 2'b11) begin
      w_grant_id = r_rr_ptr;
    end else if (req_valid[1]) begin
      w_grant_id = 1'b1;
    end
    if (!rst && (r_state == IDLE) && (req_valid != 2'b00)) begin
      w_req_ready = w_grant_id ? 2'b10 : 2'b01;
    end
  end

  assign w_accept = |(req_valid & w_req_ready);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The adder only ever sees the latched operands, so port changes after
  // acceptance cannot disturb the in-flight result.
  adder u_adder (
    .i_a     (r_a),
    .i_b     (r_b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= 1'b0;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_carry      <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id <= w_grant_id;
            r_a  <= w_grant_id ? req_a1 : req_a0;
            r_b  <= w_grant_id ? req_b1 : req_b0;
          end
        end
        EXEC: begin
          r_sum        <= w_sum;
          r_carry      <= w_carry;
          r_resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= ~r_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = w_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_id;
  assign resp_sum     = r_sum;
  assign resp_carry   = r_carry;
  assign o_dbg.state  = r_state;
  assign o_dbg.rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: expected {id, carry, sum} words are queued
// at issue time and a negedge monitor pops them against each accepted response.
module tb_adder_arbiter;
  import adder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a0, req_b0, req_a1, req_b1;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [15:0] resp_sum;
  logic        resp_carry;
  dbg_t        dbg;

  logic [17:0] exp_q[$];
  logic [17:0] cont_exp[4];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        prev_rv = 1'b0;

  adder_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry),
    .o_dbg      (dbg)
  );

  // clock / reset
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // driver tasks: entered and left at posedge + #1
  task automatic send(input bit id, input logic [15:0] a, input logic [15:0] b,
                      input logic [17:0] exp, input bit push);
    bit ok;
    ok = 1'b0;
    if (push) exp_q.push_back(exp);
    if (id) begin req_a1 = a; req_b1 = b; end
    else    begin req_a0 = a; req_b0 = b; end
    req_valid[id] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[id] === 1'b1) begin ok = 1'b1; break; end
    end
    chk("grant_seen", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && resp_valid !== 1'b1) break;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // scoreboard monitor
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        if (|(req_valid & req_ready)) acc_cyc = cyc;
        if (resp_valid === 1'b1 && !prev_rv) chk("latency", 32'(cyc - acc_cyc), 32'd2);
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", {14'd0, resp_id, resp_carry, resp_sum}, 32'h3ffff);
          end else begin
            e = exp_q.pop_front();
            chk("resp", {14'd0, resp_id, resp_carry, resp_sum}, {14'd0, e});
          end
        end
      end
      prev_rv = (resp_valid === 1'b1);
    end
  end

  initial begin
    logic [15:0] s_sum;
    logic        s_carry, s_id;
    bit          ok;

    // contention vectors, {id, carry, sum}
    cont_exp[0] = {1'b0, 1'b0, 16'h0033};  // 0011 + 0022
    cont_exp[1] = {1'b1, 1'b1, 16'h0000};  // 8000 + 8000
    cont_exp[2] = {1'b0, 1'b0, 16'h1234};  // 1000 + 0234
    cont_exp[3] = {1'b1, 1'b0, 16'hBCDE};  // ABCD + 1111

    rst = 1'b1; resp_ready = 1'b1; req_valid = 2'b11;
    req_a0 = 16'h0011; req_b0 = 16'h0022;
    req_a1 = 16'h8000; req_b1 = 16'h8000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_sum", 32'(resp_sum), 32'd0);
    chk("rst_resp_carry", 32'(resp_carry), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_state", 32'(dbg.state), 32'(IDLE));
    chk("rst_rr_ptr", 32'(dbg.rr_ptr), 32'd0);
    for (int k = 0; k < 4; k++) exp_q.push_back(cont_exp[k]);
    @(posedge clk); #1;
    rst = 1'b0;

    // contention: both valid from reset, ids alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req_ready !== 2'b00) begin ok = 1'b1; break; end
      end
      chk("cont_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk); #1;
      if (k == 0) begin req_a0 = 16'h1000; req_b0 = 16'h0234; end
      if (k == 1) begin req_a1 = 16'hABCD; req_b1 = 16'h1111; end
      if (k == 3) req_valid = 2'b00;
    end
    drain();

    // single op and overflow cases
    send(1'b0, 16'h1234, 16'h0001, {1'b0, 1'b0, 16'h1235}, 1'b1);
    drain();
    send(1'b1, 16'hFFFF, 16'h0001, {1'b1, 1'b1, 16'h0000}, 1'b1);
    drain();
    send(1'b1, 16'hFFFF, 16'hFFFF, {1'b1, 1'b1, 16'hFFFE}, 1'b1);
    drain();

    // operand hold: port change after acceptance is ignored
    send(1'b0, 16'h0100, 16'h0200, {1'b0, 1'b0, 16'h0300}, 1'b1);
    req_a0 = 16'hFFFF;
    drain();

    // back-pressure with requester 1 waiting
    resp_ready = 1'b0;
    send(1'b0, 16'h0005, 16'h0007, {1'b0, 1'b0, 16'h000C}, 1'b1);
    req_a1 = 16'h0100; req_b1 = 16'h0001; req_valid[1] = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 16'h0101});
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin ok = 1'b1; break; end
    end
    chk("bp_resp_seen", 32'(ok), 32'd1);
    s_sum = resp_sum; s_carry = resp_carry; s_id = resp_id;
    chk("bp_first_sum", 32'(s_sum), 32'h000C);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_sum_stable", 32'(resp_sum), 32'(s_sum));
      chk("bp_carry_stable", 32'(resp_carry), 32'(s_carry));
      chk("bp_id_stable", 32'(resp_id), 32'(s_id));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_after", 32'(dbg.state), 32'(IDLE));
    chk("bp_valid_low", 32'(resp_valid), 32'd0);
    chk("bp_grant1", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain();

    // reset in EXEC: op dropped, rr_ptr cleared
    send(1'b0, 16'h4444, 16'h1111, {1'b0, 1'b0, 16'h5555}, 1'b1);
    drain();
    chk("rr_before_rst", 32'(dbg.rr_ptr), 32'd1);
    send(1'b0, 16'h7777, 16'h1111, 18'd0, 1'b0);
    chk("in_exec", 32'(dbg.state), 32'(EXEC));
    rst = 1'b1; req_valid = 2'b11;
    @(negedge clk);
    chk("rst_hi_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_state", 32'(dbg.state), 32'(IDLE));
    chk("midrst_rr_ptr", 32'(dbg.rr_ptr), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_sum", 32'(resp_sum), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_a0 = 16'h0002; req_b0 = 16'h0003;
    req_a1 = 16'h0009; req_b1 = 16'h0001;
    exp_q.push_back({1'b0, 1'b0, 16'h0005});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) break;
    end
    chk("post_rst_grant0", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    repeat (6) @(posedge clk);
    #1;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
